// File: rtl/fifo_unpack_pkg.sv
// Shared constants, FSM state type and stored-entry layout for the nibble unpacking FIFO.
package fifo_unpack_pkg;

  localparam int NIB_W         = 4;
  localparam int WORD_W        = 32;
  localparam int NIBS_PER_WORD = 8;
  localparam int CNT_W         = 3;

  typedef enum logic [1:0] {
    NORMAL = 2'd0,
    FLUSH  = 2'd1,
    DONE   = 2'd2
  } state_t;

  // nibs holds the valid nibble count minus one
  typedef struct packed {
    logic [CNT_W-1:0]  nibs;
    logic [WORD_W-1:0] data;
  } entry_t;

endpackage

// File: rtl/fifo_unpack_flush_if.sv
// Write/read/flush bundle of the unpacking FIFO; error flags exist only when FIFO_ERR_FLAGS_EN is defined.
interface fifo_unpack_flush_if;
  import fifo_unpack_pkg::*;

  logic                  fifo_wr_valid_i;
  logic [WORD_W-1:0]     fifo_wr_data_i;
  logic [CNT_W-1:0]      fifo_wr_nibs_i;
  logic                  fifo_rd_valid_i;
  logic                  fifo_flush_i;
  logic [NIB_W-1:0]      fifo_rd_data_o;
  logic                  fifo_data_avail_o;
  logic                  fifo_empty_o;
  logic                  fifo_full_o;
  logic                  fifo_flush_done_o;
`ifdef FIFO_ERR_FLAGS_EN
  logic                  fifo_overflow_o;
  logic                  fifo_underflow_o;
`endif

  modport master (
    output fifo_wr_valid_i,
    output fifo_wr_data_i,
    output fifo_wr_nibs_i,
    output fifo_rd_valid_i,
    output fifo_flush_i,
    input  fifo_rd_data_o,
    input  fifo_data_avail_o,
    input  fifo_empty_o,
    input  fifo_full_o,
    input  fifo_flush_done_o
`ifdef FIFO_ERR_FLAGS_EN
    ,
    input  fifo_overflow_o,
    input  fifo_underflow_o
`endif
  );

  modport slave (
    input  fifo_wr_valid_i,
    input  fifo_wr_data_i,
    input  fifo_wr_nibs_i,
    input  fifo_rd_valid_i,
    input  fifo_flush_i,
    output fifo_rd_data_o,
    output fifo_data_avail_o,
    output fifo_empty_o,
    output fifo_full_o,
    output fifo_flush_done_o
`ifdef FIFO_ERR_FLAGS_EN
    ,
    output fifo_overflow_o,
    output fifo_underflow_o
`endif
  );

endinterface

// File: rtl/fifo_unpack_mem.sv
// Word storage: DEPTH entries of data plus nibble count, synchronous write, asynchronous read, no reset.
module fifo_unpack_mem
  import fifo_unpack_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             clock,
  input  logic             wr_en,
  input  logic [PTR_W-1:0] wr_addr,
  input  entry_t           wr_entry,
  input  logic [PTR_W-1:0] rd_addr,
  output entry_t           rd_entry
);

  entry_t mem [DEPTH];

  always_ff @(posedge clock) begin
    if (wr_en) mem[wr_addr] <= wr_entry;
  end

  assign rd_entry = mem[rd_addr];

endmodule

// File: rtl/fifo_unpack_flush.sv
// 32-bit to 4-bit unpacking FIFO with per-word nibble count and flush/drain handshake.
// Optional sticky overflow/underflow flags are built when FIFO_ERR_FLAGS_EN is defined.
//
// state  | meaning
// NORMAL | writes and reads accepted
// FLUSH  | writes blocked, draining stored nibbles
// DONE   | drained, flush_done high until flush request drops
module fifo_unpack_flush
  import fifo_unpack_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic              clock,
  input  logic              reset,
  fifo_unpack_flush_if.slave bus
);

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   occ;
  logic [PTR_W:0]   occ_next;
  logic [CNT_W-1:0] idx;
  state_t           state;
  logic             done;
  entry_t           head;
  entry_t           wr_entry;
  logic             empty;
  logic             full;
  logic             wr_acc;
  logic             rd_acc;
  logic             pop;

  assign empty  = (occ == '0);
  assign full   = (occ == (PTR_W+1)'(DEPTH));
  assign wr_acc = bus.fifo_wr_valid_i && !full && (state == NORMAL);
  assign rd_acc = bus.fifo_rd_valid_i && !empty;
  assign pop    = rd_acc && (idx == head.nibs);

  assign wr_entry.data = bus.fifo_wr_data_i;
  assign wr_entry.nibs = bus.fifo_wr_nibs_i;

  fifo_unpack_mem #(.DEPTH(DEPTH)) u_mem (
    .clock    (clock),
    .wr_en    (wr_acc),
    .wr_addr  (wr_ptr),
    .wr_entry (wr_entry),
    .rd_addr  (rd_ptr),
    .rd_entry (head)
  );

  always_comb begin
    occ_next = occ;
    case ({wr_acc, pop})
      2'b10:   occ_next = occ + (PTR_W+1)'(1);
      2'b01:   occ_next = occ - (PTR_W+1)'(1);
      default: occ_next = occ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
      idx    <= '0;
      state  <= NORMAL;
      done   <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + PTR_W'(1);
      if (rd_acc) begin
        if (pop) begin
          idx    <= '0;
          rd_ptr <= rd_ptr + PTR_W'(1);
        end else begin
          idx <= idx + CNT_W'(1);
        end
      end
      occ <= occ_next;

      case (state)
        NORMAL: begin
          if (bus.fifo_flush_i) state <= FLUSH;
        end
        // writes are blocked here, so occ_next==0 also covers "already empty"
        FLUSH: begin
          if (occ_next == '0) begin
            state <= DONE;
            done  <= 1'b1;
          end
        end
        DONE: begin
          if (!bus.fifo_flush_i) begin
            state <= NORMAL;
            done  <= 1'b0;
          end
        end
        default: begin
          state <= NORMAL;
          done  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.fifo_rd_data_o    = empty ? '0 : head.data[{idx, 2'b00} +: NIB_W];
  assign bus.fifo_data_avail_o = !empty;
  assign bus.fifo_empty_o      = empty;
  assign bus.fifo_full_o       = full;
  assign bus.fifo_flush_done_o = done;

`ifdef FIFO_ERR_FLAGS_EN
  logic overflow;
  logic underflow;

  always_ff @(posedge clock) begin
    if (reset) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (bus.fifo_wr_valid_i && !wr_acc) overflow  <= 1'b1;
      if (bus.fifo_rd_valid_i && empty)   underflow <= 1'b1;
    end
  end

  assign bus.fifo_overflow_o  = overflow;
  assign bus.fifo_underflow_o = underflow;
`endif

endmodule

// File: tb/tb_fifo_unpack_flush.sv
// Scoreboard bench for fifo_unpack_flush; flag checks are built when FIFO_ERR_FLAGS_EN is defined.
module tb_fifo_unpack_flush;

  logic clock = 1'b0;
  logic reset = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;
  logic [3:0] exp_q[$];

  fifo_unpack_flush_if bus ();

  fifo_unpack_flush #(.DEPTH(4)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL timeout: got no finish, expected finish before 200000");
    $fatal(1, "timeout");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic push_word(input logic [31:0] d, input logic [2:0] n);
    for (int i = 0; i <= int'(n); i++) exp_q.push_back(d[4*i +: 4]);
  endtask

  task automatic check_head(input string tag);
    logic [3:0] e;
    e = (exp_q.size() != 0) ? exp_q[0] : 4'h0;
    check_eq({tag, "_data"}, 32'(bus.fifo_rd_data_o), 32'(e));
    check_eq({tag, "_avail"}, 32'(bus.fifo_data_avail_o), 32'(exp_q.size() != 0));
  endtask

  task automatic do_write(input logic [31:0] d, input logic [2:0] n, input bit ok);
    bus.fifo_wr_valid_i = 1'b1;
    bus.fifo_wr_data_i  = d;
    bus.fifo_wr_nibs_i  = n;
    step();
    bus.fifo_wr_valid_i = 1'b0;
    if (ok) push_word(d, n);
  endtask

  task automatic do_read(input string tag);
    check_head(tag);
    bus.fifo_rd_valid_i = 1'b1;
    step();
    bus.fifo_rd_valid_i = 1'b0;
    if (exp_q.size() != 0) void'(exp_q.pop_front());
  endtask

  task automatic do_write_read(input logic [31:0] d, input logic [2:0] n, input bit ok, input string tag);
    check_head(tag);
    bus.fifo_wr_valid_i = 1'b1;
    bus.fifo_wr_data_i  = d;
    bus.fifo_wr_nibs_i  = n;
    bus.fifo_rd_valid_i = 1'b1;
    step();
    bus.fifo_wr_valid_i = 1'b0;
    bus.fifo_rd_valid_i = 1'b0;
    if (exp_q.size() != 0) void'(exp_q.pop_front());
    if (ok) push_word(d, n);
  endtask

  task automatic check_reset_state(input string tag);
    check_eq({tag, "_rd_data"}, 32'(bus.fifo_rd_data_o), 32'h0);
    check_eq({tag, "_avail"},   32'(bus.fifo_data_avail_o), 32'h0);
    check_eq({tag, "_empty"},   32'(bus.fifo_empty_o), 32'h1);
    check_eq({tag, "_full"},    32'(bus.fifo_full_o), 32'h0);
    check_eq({tag, "_done"},    32'(bus.fifo_flush_done_o), 32'h0);
  endtask

  initial begin
    bus.fifo_wr_valid_i = 1'b0;
    bus.fifo_wr_data_i  = '0;
    bus.fifo_wr_nibs_i  = '0;
    bus.fifo_rd_valid_i = 1'b0;
    bus.fifo_flush_i    = 1'b0;
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    check_reset_state("reset");
`ifdef FIFO_ERR_FLAGS_EN
    check_eq("reset_ovf", 32'(bus.fifo_overflow_o), 32'h0);
    check_eq("reset_udf", 32'(bus.fifo_underflow_o), 32'h0);
`endif

    // full 8-nibble word, LSB nibble first
    do_write(32'h8765_4321, 3'd7, 1'b1);
    check_eq("full_word_avail", 32'(bus.fifo_data_avail_o), 32'h1);
    for (int i = 0; i < 8; i++) do_read($sformatf("fw_rd%0d", i));
    check_eq("full_word_empty", 32'(bus.fifo_empty_o), 32'h1);

    // partial word, third read ignored
    do_write(32'h0000_00BA, 3'd1, 1'b1);
    do_read("pw_rd0");
    do_read("pw_rd1");
    do_read("pw_rd2");
    check_eq("pw_empty", 32'(bus.fifo_empty_o), 32'h1);
    check_eq("pw_rd_data", 32'(bus.fifo_rd_data_o), 32'h0);

    // full boundary: fifth word dropped
    for (int w = 1; w <= 4; w++) begin
      check_eq($sformatf("fb_full_before%0d", w), 32'(bus.fifo_full_o), 32'h0);
      do_write({8{4'(w)}}, 3'd7, 1'b1);
    end
    check_eq("fb_full", 32'(bus.fifo_full_o), 32'h1);
    do_write(32'h5555_5555, 3'd7, 1'b0);
    check_eq("fb_full_held", 32'(bus.fifo_full_o), 32'h1);
    for (int i = 0; i < 32; i++) begin
      do_read($sformatf("fb_rd%0d", i));
      if (i == 0) check_eq("fb_partial_head_full", 32'(bus.fifo_full_o), 32'h1);
    end
    check_eq("fb_empty", 32'(bus.fifo_empty_o), 32'h1);
    do_read("fb_rd_extra");

    // at full, a read freeing the head does not admit a same-cycle write
    for (int w = 1; w <= 4; w++) do_write(32'(w), 3'd0, 1'b1);
    check_eq("fr_full", 32'(bus.fifo_full_o), 32'h1);
    do_write_read(32'hF, 3'd0, 1'b0, "fr_at_full");
    check_eq("fr_not_full", 32'(bus.fifo_full_o), 32'h0);
    do_write_read(32'h6, 3'd0, 1'b1, "fr_mid");
    check_eq("fr_mid_not_full", 32'(bus.fifo_full_o), 32'h0);
    for (int i = 0; i < 3; i++) do_read($sformatf("fr_rd%0d", i));
    check_eq("fr_empty", 32'(bus.fifo_empty_o), 32'h1);

    // write at empty plus read: read ignored, write stored
    do_write_read(32'h9, 3'd0, 1'b1, "we_re");
    do_read("we_re_rd");
    check_eq("we_re_empty", 32'(bus.fifo_empty_o), 32'h1);

    // flush drains, blocks writes, then releases
    do_write(32'hFEDC_BA98, 3'd7, 1'b1);
    do_write(32'h7654_3210, 3'd7, 1'b1);
    bus.fifo_flush_i = 1'b1;
    step();
    do_write(32'hAAAA_AAAA, 3'd7, 1'b0);
    do_write(32'hAAAA_AAAA, 3'd7, 1'b0);
    for (int i = 0; i < 16; i++) begin
      check_eq($sformatf("fl_done_low%0d", i), 32'(bus.fifo_flush_done_o), 32'h0);
      do_read($sformatf("fl_rd%0d", i));
    end
    check_eq("fl_done", 32'(bus.fifo_flush_done_o), 32'h1);
    check_eq("fl_empty", 32'(bus.fifo_empty_o), 32'h1);
    do_write(32'hAAAA_AAAA, 3'd7, 1'b0);
    step();
    check_eq("fl_done_held", 32'(bus.fifo_flush_done_o), 32'h1);
    check_eq("fl_done_no_data", 32'(bus.fifo_data_avail_o), 32'h0);
    bus.fifo_flush_i = 1'b0;
    step();
    check_eq("fl_done_clear", 32'(bus.fifo_flush_done_o), 32'h0);
    do_write(32'h0000_00C3, 3'd1, 1'b1);
    do_read("fl_post_rd0");
    do_read("fl_post_rd1");
    check_eq("fl_post_empty", 32'(bus.fifo_empty_o), 32'h1);

    // flush request dropped early: drain completes, done pulses one cycle
    do_write(32'h0000_0021, 3'd1, 1'b1);
    bus.fifo_flush_i = 1'b1;
    step();
    bus.fifo_flush_i = 1'b0;
    do_read("fe_rd0");
    check_eq("fe_done_low", 32'(bus.fifo_flush_done_o), 32'h0);
    do_read("fe_rd1");
    check_eq("fe_done_pulse", 32'(bus.fifo_flush_done_o), 32'h1);
    step();
    check_eq("fe_done_gone", 32'(bus.fifo_flush_done_o), 32'h0);
    do_write(32'h0000_0004, 3'd0, 1'b1);
    do_read("fe_post_rd");

    // reset during flush with a stored word
    do_write(32'h1234_5678, 3'd7, 1'b1);
    bus.fifo_flush_i = 1'b1;
    step();
    do_read("rs_rd0");
    reset = 1'b1;
    step();
    reset = 1'b0;
    bus.fifo_flush_i = 1'b0;
    exp_q.delete();
    check_reset_state("rs_mid_flush");
    step();
    do_write(32'h0000_000D, 3'd0, 1'b1);
    do_read("rs_post_rd");

`ifdef FIFO_ERR_FLAGS_EN
    check_eq("ef_udf_clear", 32'(bus.fifo_underflow_o), 32'h0);
    do_read("ef_udf_rd");
    check_eq("ef_udf_set", 32'(bus.fifo_underflow_o), 32'h1);
    step();
    step();
    check_eq("ef_udf_sticky", 32'(bus.fifo_underflow_o), 32'h1);
    check_eq("ef_ovf_clear", 32'(bus.fifo_overflow_o), 32'h0);
    for (int w = 0; w < 4; w++) do_write(32'(w), 3'd0, 1'b1);
    do_write(32'hE, 3'd0, 1'b0);
    check_eq("ef_ovf_set", 32'(bus.fifo_overflow_o), 32'h1);
    for (int i = 0; i < 4; i++) do_read($sformatf("ef_rd%0d", i));
    check_eq("ef_ovf_sticky", 32'(bus.fifo_overflow_o), 32'h1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check_eq("ef_ovf_reset", 32'(bus.fifo_overflow_o), 32'h0);
    check_eq("ef_udf_reset", 32'(bus.fifo_underflow_o), 32'h0);
`endif

    check_eq("final_queue_empty", 32'(exp_q.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/fifo_unpack_flush.md
Name: fifo_unpack_flush

Overview:
- Width-down companion to the nibble-packing flush FIFO. It accepts 32-bit words on the write side and returns them as 4-bit nibbles on the read side, least-significant nibble first.
- Each written word carries a valid-nibble count, so partial words written at a flush boundary are unpacked without padding.
- A flush request puts the block into drain mode: writes are blocked until all stored nibbles have been read, then flush completion is signalled.
- It sits on the consumer side of a packed 32-bit link.

Parameters:
- DEPTH, 4, number of 32-bit word entries (power of two, >=2)
- PTR_W, $clog2(DEPTH), word pointer width (derived, not overridden)

Ports:
- clock  input  1  system clock, all logic on rising edge
- reset  input  1  synchronous, active-high reset
- fifo_wr_valid_i  input  1  write strobe, one word per asserted cycle
- fifo_wr_data_i  input  32  write word, nibble 0 = bits [3:0]
- fifo_wr_nibs_i  input  3  valid nibble count minus 1 (0 -> 1 nibble, 7 -> 8 nibbles)
- fifo_rd_valid_i  input  1  read/pop strobe, one nibble per asserted cycle
- fifo_flush_i  input  1  flush request, level
- fifo_rd_data_o  output  4  head nibble, first-word-fall-through
- fifo_data_avail_o  output  1  at least one nibble stored
- fifo_empty_o  output  1  no nibbles stored
- fifo_full_o  output  1  DEPTH word entries occupied
- fifo_flush_done_o  output  1  drain complete

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high.
- Reset values: pointers 0, nibble index 0, occupancy 0, state NORMAL, fifo_rd_data_o=0, fifo_data_avail_o=0, fifo_empty_o=1, fifo_full_o=0, fifo_flush_done_o=0.
- Reset mid-operation (including mid-flush) discards all contents in the same edge.
- Write:
  - Accepted when fifo_wr_valid_i=1 && !fifo_full_o && state==NORMAL.
  - Stores the word and its count at the write pointer; occupancy +1.
  - Data is visible on fifo_rd_data_o the next cycle.
  - Writes that are not accepted are dropped silently.
- Read:
  - Accepted when fifo_rd_valid_i=1 && fifo_data_avail_o.
  - The nibble index advances by 1.
  - When the index equals the head count, the index resets to 0, the read pointer advances and occupancy -1.
  - A read while empty is ignored.
- fifo_rd_data_o: combinational head nibble, mem[rd_ptr][4*idx+:4]; 0 when empty.
- Status flags:
  - fifo_full_o = (occupancy==DEPTH). A partially consumed head still counts as occupied.
  - fifo_empty_o = (occupancy==0); fifo_data_avail_o = !fifo_empty_o.
- Simultaneous events:
  - Write and read in the same cycle with occupancy between 0 and DEPTH: both are performed.
  - At full, a read that frees the head does not allow a same-cycle write; full is the registered value.
  - Write at empty plus read in the same cycle: the read is ignored.
- Pointers wrap modulo DEPTH.
- State machine:
  - NORMAL -> FLUSH when fifo_flush_i=1.
  - FLUSH: writes blocked, reads serviced. Go to DONE on the edge where occupancy becomes 0, or immediately if already empty.
  - DONE: fifo_flush_done_o=1 (registered, rises the cycle after the last nibble is read). Stay while fifo_flush_i=1; go to NORMAL when fifo_flush_i=0.
  - FLUSH with fifo_flush_i dropped early: draining still completes, DONE is asserted for one cycle, then the block returns to NORMAL.

Optional Feature:
- Macro: FIFO_ERR_FLAGS_EN.
- When defined, two outputs are added: fifo_overflow_o and fifo_underflow_o, each 1 bit.
  - fifo_overflow_o sets on any write that is dropped (full or not NORMAL).
  - fifo_underflow_o sets on a read while empty.
  - Both are sticky until reset; reset value 0.
- When undefined, the ports and logic are absent and dropped accesses are silent.

Decomposition:
- Package fifo_unpack_pkg:
  - constants NIB_W=4, WORD_W=32, NIBS_PER_WORD=8, CNT_W=3
  - state typedef {NORMAL, FLUSH, DONE}
- Sub-module fifo_unpack_mem:
  - DEPTH x (32+3) register array
  - synchronous write port, asynchronous read port
  - no reset on the array
- Top level holds the pointers, nibble index, occupancy, FSM and flags.

Test Plan:
- Full word: reset 2 cycles, write 0x87654321 with nibs=7, then read 8 cycles -> rd_data 1,2,...,8; empty_o=1 on the cycle after the 8th read.
- Partial word: write 0x000000BA with nibs=1 -> reads return A then B; a third read is ignored, rd_data=0, avail=0.
- Full boundary (DEPTH=4): write 5 words 0x11111111..0x55555555 -> full_o=1 after 4; 5th dropped; 32 reads return only nibbles 1..4.
- Full with same-cycle read: at full, write plus the read freeing the head -> write dropped; occupancy 3, full_o=0 next cycle.
- Flush: store 2 full words, raise flush_i, attempt writes of 0xAAAAAAAA, read 16 nibbles -> writes ignored; flush_done_o=1 on the cycle after the 16th read; held while flush_i=1; drop flush_i -> NORMAL and a write accepted.
- Reset and error flags: assert reset during FLUSH with 1 word stored -> all outputs at reset values next cycle. With FIFO_ERR_FLAGS_EN, a read while empty -> underflow_o=1 and stays sticky.
